// File: rtl/freq_div_pkg.sv
// ---------------------------------------------------------------------------
// freq_div_pkg
// Shared types and helpers for the freq_div_bank programmable divider bank.
//   fd_state_e : per-channel state (FD_RUN counting, FD_DONE one-shot finished)
//   fd_cfg_t   : latched channel configuration (terminal value, one-shot mode)
//   fd_ch_w()  : width of the channel-select field for a given channel count
// ---------------------------------------------------------------------------
package freq_div_pkg;

  // Widest supported divide value; narrower channels zero-extend into it.
  localparam int FD_MAX_W = 32;

  typedef enum logic {
    FD_RUN  = 1'b0,
    FD_DONE = 1'b1
  } fd_state_e;

  typedef struct packed {
    logic [FD_MAX_W-1:0] div;
    logic                oneshot;
  } fd_cfg_t;

  // A single channel still needs a 1-bit select so the port never collapses.
  function automatic int fd_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/freq_div_chan.sv
// ---------------------------------------------------------------------------
// freq_div_chan
// One channel of the divider bank: WIDTH-bit up-counter with a run-time
// terminal value, free-run or one-shot mode, terminal-count tick, divided
// square wave and sticky done flag. All outputs are registered.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   enable_i       count enable
//   clear_i        synchronous clear (keeps latched configuration)
//   cfg_wr_i       configuration write addressed to this channel
//   cfg_div_i      terminal value; period is cfg_div_i+1 enabled cycles
//   cfg_oneshot_i  1 = one-shot, 0 = free-run
//   count_o        current count
//   tick_o         one-cycle pulse after the terminal edge
//   div_clk_o      toggles on every tick
//   done_o         one-shot completion flag, sticky
//
// state   | meaning
// --------+------------------------------------------------------------
// FD_RUN  | counting on enabled cycles, wraps (free-run) or finishes
// FD_DONE | one-shot finished; count/div_clk/done hold, enable ignored
// ---------------------------------------------------------------------------
module freq_div_chan
  import freq_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             cfg_wr_i,
  input  logic [WIDTH-1:0] cfg_div_i,
  input  logic             cfg_oneshot_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             div_clk_o,
  output logic             done_o
);

  localparam logic [FD_MAX_W-1:0] RST_DIV = FD_MAX_W'(WIDTH'(DEFAULT_DIV));

  fd_state_e        state_q;
  fd_cfg_t          cfg_q;
  logic [WIDTH-1:0] count_q;
  logic             tick_q;
  logic             div_clk_q;
  logic             done_q;
  logic             at_term;

  // The latched divide value is zero-extended, so comparing at full width
  // is exact for any WIDTH.
  assign at_term = (FD_MAX_W'(count_q) == cfg_q.div);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FD_RUN;
      cfg_q.div   <= RST_DIV;
      cfg_q.oneshot <= 1'b0;
      count_q     <= '0;
      tick_q      <= 1'b0;
      div_clk_q   <= 1'b0;
      done_q      <= 1'b0;
    end else if (cfg_wr_i) begin
      // A write restarts the channel and discards any count in progress,
      // even on the terminal cycle.
      cfg_q.div     <= FD_MAX_W'(cfg_div_i);
      cfg_q.oneshot <= cfg_oneshot_i;
      state_q       <= FD_RUN;
      count_q       <= '0;
      tick_q        <= 1'b0;
      div_clk_q     <= 1'b0;
      done_q        <= 1'b0;
    end else if (clear_i) begin
      state_q   <= FD_RUN;
      count_q   <= '0;
      tick_q    <= 1'b0;
      div_clk_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        FD_RUN: begin
          if (enable_i) begin
            if (at_term) begin
              tick_q    <= 1'b1;
              div_clk_q <= ~div_clk_q;
              if (cfg_q.oneshot) begin
                // count stays parked at the terminal value
                done_q  <= 1'b1;
                state_q <= FD_DONE;
              end else begin
                count_q <= '0;
              end
            end else begin
              count_q <= count_q + WIDTH'(1);
            end
          end
        end
        FD_DONE: begin
          state_q <= FD_DONE;
        end
        default: begin
          state_q <= FD_RUN;
        end
      endcase
    end
  end

  assign count_o   = count_q;
  assign tick_o    = tick_q;
  assign div_clk_o = div_clk_q;
  assign done_o    = done_q;

endmodule

// File: rtl/freq_div_bank.sv
// ---------------------------------------------------------------------------
// freq_div_bank
// NUM_CH independent programmable frequency dividers. Decodes the shared
// configuration port into per-channel write strobes and packs the counts.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   enable_i       per-channel count enable
//   clear_i        per-channel synchronous clear
//   cfg_wr_i       configuration write strobe
//   cfg_ch_i       target channel; values >= NUM_CH are ignored
//   cfg_div_i      terminal value (period = cfg_div_i+1 enabled cycles)
//   cfg_oneshot_i  1 = one-shot, 0 = free-run
//   count_o        packed counts, channel i at [i*WIDTH +: WIDTH]
//   tick_o         per-channel terminal-count pulse
//   div_clk_o      per-channel divided square wave
//   done_o         per-channel sticky one-shot completion flag
// ---------------------------------------------------------------------------
module freq_div_bank
  import freq_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int WIDTH       = 8,
  parameter  int DEFAULT_DIV = 1,
  localparam int CH_W        = fd_ch_w(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       enable_i,
  input  logic [NUM_CH-1:0]       clear_i,
  input  logic                    cfg_wr_i,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [WIDTH-1:0]        cfg_div_i,
  input  logic                    cfg_oneshot_i,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       div_clk_o,
  output logic [NUM_CH-1:0]       done_o
);

  logic [NUM_CH-1:0] wr_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range selects never match any index, so they are dropped here.
    assign wr_sel[i] = cfg_wr_i && (cfg_ch_i == CH_W'(i));

    freq_div_chan #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .enable_i     (enable_i[i]),
      .clear_i      (clear_i[i]),
      .cfg_wr_i     (wr_sel[i]),
      .cfg_div_i    (cfg_div_i),
      .cfg_oneshot_i(cfg_oneshot_i),
      .count_o      (count_o[i*WIDTH +: WIDTH]),
      .tick_o       (tick_o[i]),
      .div_clk_o    (div_clk_o[i]),
      .done_o       (done_o[i])
    );
  end

endmodule

// File: tb/tb_freq_div_bank.sv
module tb_freq_div_bank;

  localparam int NUM_CH      = 4;
  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 1;
  localparam int CH_W        = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       clear;
  logic                    cfg_wr;
  logic [CH_W-1:0]         cfg_ch;
  logic [WIDTH-1:0]        cfg_div;
  logic                    cfg_os;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       div_clk;
  logic [NUM_CH-1:0]       done;

  int checks = 0;
  int errors = 0;

  freq_div_bank #(
    .NUM_CH     (NUM_CH),
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .clear_i      (clear),
    .cfg_wr_i     (cfg_wr),
    .cfg_ch_i     (cfg_ch),
    .cfg_div_i    (cfg_div),
    .cfg_oneshot_i(cfg_os),
    .count_o      (count),
    .tick_o       (tick),
    .div_clk_o    (div_clk),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Reference model: each channel is described by how many enabled cycles
  // it has counted since its last restart; all outputs follow arithmetically.
  longint           m_n   [NUM_CH];
  logic [WIDTH-1:0] m_div [NUM_CH];
  logic             m_os  [NUM_CH];
  logic             m_inc [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_n[c]   = 0;
      m_div[c] = WIDTH'(DEFAULT_DIV);
      m_os[c]  = 1'b0;
      m_inc[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      longint p;
      p = longint'(m_div[c]) + 1;
      if (cfg_wr && int'(cfg_ch) == c) begin
        m_div[c] = cfg_div;
        m_os[c]  = cfg_os;
        m_n[c]   = 0;
        m_inc[c] = 1'b0;
      end else if (clear[c]) begin
        m_n[c]   = 0;
        m_inc[c] = 1'b0;
      end else if (enable[c] && !(m_os[c] && m_n[c] >= p)) begin
        m_n[c]   = m_n[c] + 1;
        m_inc[c] = 1'b1;
      end else begin
        m_inc[c] = 1'b0;
      end
    end
  endtask

  function automatic logic [WIDTH+2:0] model_exp(input int c);
    longint           p;
    logic [WIDTH-1:0] cnt;
    logic             tk, dc, dn;
    p = longint'(m_div[c]) + 1;
    if (m_os[c]) begin
      dn  = (m_n[c] >= p);
      cnt = dn ? m_div[c] : WIDTH'(m_n[c]);
      dc  = dn;
      tk  = m_inc[c] && dn;
    end else begin
      cnt = WIDTH'(m_n[c] % p);
      tk  = m_inc[c] && ((m_n[c] % p) == 0);
      dc  = ((m_n[c] / p) % 2) == 1;
      dn  = 1'b0;
    end
    return {cnt, tk, dc, dn};
  endfunction

  function automatic logic [WIDTH+2:0] dut_out(input int c);
    return {count[c*WIDTH +: WIDTH], tick[c], div_clk[c], done[c]};
  endfunction

  task automatic check(input string name, input int c,
                       input logic [WIDTH+2:0] act, input logic [WIDTH+2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got cnt=%0d tick=%b div_clk=%b done=%b, expected cnt=%0d tick=%b div_clk=%b done=%b",
               name, c, act[WIDTH+2:3], act[2], act[1], act[0],
               exp[WIDTH+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_model(input string name);
    for (int c = 0; c < NUM_CH; c++) check(name, c, dut_out(c), model_exp(c));
  endtask

  task automatic set_in(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] clr,
                        input logic wr, input logic [CH_W-1:0] ch,
                        input logic [WIDTH-1:0] dv, input logic os);
    enable  = en;
    clear   = clr;
    cfg_wr  = wr;
    cfg_ch  = ch;
    cfg_div = dv;
    cfg_os  = os;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH+2:0] pk(input int cnt, input logic tk,
                                          input logic dc, input logic dn);
    return {WIDTH'(cnt), tk, dc, dn};
  endfunction

  // Directed vector table: inputs for one edge and the expected state of one
  // channel after it.
  typedef struct {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] clr;
    logic              wr;
    logic [CH_W-1:0]   ch;
    logic [WIDTH-1:0]  dv;
    logic              os;
    int                chk;
    logic [WIDTH+2:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] clr,
                              input logic wr, input int ch, input int dv, input logic os,
                              input int chk, input int cnt, input logic tk,
                              input logic dc, input logic dn);
    vec_t v;
    v.en  = en;
    v.clr = clr;
    v.wr  = wr;
    v.ch  = CH_W'(ch);
    v.dv  = WIDTH'(dv);
    v.os  = os;
    v.chk = chk;
    v.exp = pk(cnt, tk, dc, dn);
    vecs.push_back(v);
  endfunction

  task automatic hand(input string name, input int c, input int cnt,
                      input logic tk, input logic dc, input logic dn);
    check(name, c, dut_out(c), pk(cnt, tk, dc, dn));
    check_model({name, "_model"});
  endtask

  initial begin
    rst_n = 1'b0;
    set_in('0, '0, 1'b0, '0, '0, 1'b0);
    model_reset();
    #2;
    for (int c = 0; c < NUM_CH; c++) check("reset", c, dut_out(c), pk(0, 0, 0, 0));
    #10;
    rst_n = 1'b1;

    // ch0 default divide of 1
    add(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    // ch1 div=0 free-run
    add(4'b0001, 4'b0000, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    add(4'b0011, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    add(4'b0011, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(4'b0011, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    // ch2 div=5 one-shot
    add(4'b0011, 4'b0000, 1, 2, 5, 1, 2, 0, 0, 0, 0);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 2, 0, 0, 0);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 3, 0, 0, 0);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 4, 0, 0, 0);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 5, 0, 0, 0);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 5, 1, 1, 1);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 5, 0, 1, 1);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 5, 0, 1, 1);
    add(4'b0111, 4'b0100, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    add(4'b0111, 4'b0000, 0, 0, 0, 0, 2, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].en, vecs[i].clr, vecs[i].wr, vecs[i].ch, vecs[i].dv, vecs[i].os);
      step();
      check($sformatf("vec%0d", i), vecs[i].chk, dut_out(vecs[i].chk), vecs[i].exp);
      check_model($sformatf("vec%0d_model", i));
    end

    // ch0 div=7: pause at count 3, then resume
    set_in(4'b0000, '0, 1'b1, 2'd0, 8'd7, 1'b0);
    step();
    set_in(4'b0001, '0, 1'b0, 2'd0, 8'd0, 1'b0);
    repeat (3) step();
    hand("pause_pre", 0, 3, 0, 0, 0);
    enable = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      hand("pause_hold", 0, 3, 0, 0, 0);
    end
    enable = 4'b0001;
    step();
    hand("pause_resume", 0, 4, 0, 0, 0);
    repeat (3) step();
    hand("pause_term", 0, 7, 0, 0, 0);
    step();
    hand("pause_wrap", 0, 0, 1, 1, 0);

    // ch3: cfg_wr + clear + terminal on one edge
    set_in(4'b1000, '0, 1'b1, 2'd3, 8'd4, 1'b0);
    step();
    cfg_wr = 1'b0;
    repeat (4) step();
    hand("coinc_pre", 3, 4, 0, 0, 0);
    set_in(4'b1000, 4'b1000, 1'b1, 2'd3, 8'd2, 1'b0);
    step();
    hand("coinc_edge", 3, 0, 0, 0, 0);
    set_in(4'b1000, '0, 1'b0, 2'd0, 8'd0, 1'b0);
    step();
    hand("coinc_p1", 3, 1, 0, 0, 0);
    step();
    hand("coinc_p2", 3, 2, 0, 0, 0);
    step();
    hand("coinc_p3", 3, 0, 1, 1, 0);

    // ch0 div=255: full 2^WIDTH period
    set_in(4'b0000, '0, 1'b1, 2'd0, 8'd255, 1'b0);
    step();
    set_in(4'b0001, '0, 1'b0, 2'd0, 8'd0, 1'b0);
    for (int k = 0; k < 255; k++) begin
      step();
      check_model("div_max_run");
    end
    hand("div_max_top", 0, 255, 0, 0, 0);
    step();
    hand("div_max_wrap", 0, 0, 1, 1, 0);

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      enable = NUM_CH'($urandom | $urandom);
      for (int b = 0; b < NUM_CH; b++) clear[b] = ($urandom_range(0, 15) == 0);
      cfg_wr  = ($urandom_range(0, 7) == 0);
      cfg_ch  = CH_W'($urandom);
      cfg_div = ($urandom_range(0, 4) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      cfg_os  = 1'($urandom);
      step();
      check_model("random");
    end

    // asynchronous reset mid-count, between clock edges
    set_in(4'b1111, '0, 1'b0, 2'd0, 8'd0, 1'b0);
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NUM_CH; c++) check("async_reset", c, dut_out(c), pk(0, 0, 0, 0));
    model_reset();
    set_in('0, '0, 1'b0, '0, '0, 1'b0);
    #2;
    rst_n = 1'b1;
    enable = 4'b0001;
    step();
    hand("post_reset_1", 0, 1, 0, 0, 0);
    step();
    hand("post_reset_2", 0, 0, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_div_bank.md
# freq_div_bank

Multi-channel programmable frequency divider and the parametrised successor to the fixed 1/2 and 1/4 rate counters. Each of NUM_CH channels runs a WIDTH-bit up-counter with a run-time divide value, free-run or one-shot mode, per-channel enable and clear. Each channel produces a terminal-count tick, a divided clock-enable square wave and a done flag. The block sits beside the clock/reset tree and feeds rate strobes to downstream datapath blocks.

## Interface
- NUM_CH, 4, number of independent channels (>=1)
- WIDTH, 8, counter and divide-value width (2..32)
- DEFAULT_DIV, 1, terminal value loaded into every channel at reset
- CH_W, max(1,$clog2(NUM_CH)), derived, channel-select width (not overridden)

- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- enable  in  NUM_CH  per-channel count enable
- clear  in  NUM_CH  per-channel synchronous clear
- cfg_wr  in  1  configuration write strobe
- cfg_ch  in  CH_W  target channel of cfg_wr; values >= NUM_CH are ignored
- cfg_div  in  WIDTH  terminal value; channel period = cfg_div+1 enabled cycles
- cfg_oneshot  in  1  1 = one-shot mode, 0 = free-run mode
- count  out  NUM_CH*WIDTH  current count, channel i at [i*WIDTH +: WIDTH]
- tick  out  NUM_CH  one-cycle pulse on terminal count
- div_clk  out  NUM_CH  toggles on every tick (period 2*(div+1) enabled cycles)
- done  out  NUM_CH  one-shot completion flag, sticky

## Operation
- Per-channel states: RUN, DONE. Reset state: RUN, count=0, tick=0, div_clk=0, done=0, div=DEFAULT_DIV, mode=free-run.
- Per-channel priority, highest first: reset > cfg_wr addressed to the channel > clear > enable-driven counting.
- cfg_wr: latches div and mode, count<=0, div_clk<=0, done<=0, state<=RUN, tick<=0. Any count in progress is discarded.
- clear: count<=0, div_clk<=0, done<=0, state<=RUN, tick<=0. Latched div and mode are kept.
- RUN, enable=1, count!=div: count<=count+1, tick<=0.
- RUN, enable=1, count==div, free-run: count<=0, tick<=1, div_clk toggles.
- RUN, enable=1, count==div, one-shot: count holds at div, tick<=1, div_clk toggles, done<=1, state<=DONE.
- RUN, enable=0: count and div_clk hold, tick<=0.
- DONE: count, div_clk and done hold, tick<=0. enable is ignored. Only clear, cfg_wr or reset leave DONE.
- div=0: in free-run, tick stays high on every enabled cycle and div_clk toggles every enabled cycle. In one-shot, it completes on the first enabled cycle.
- Counter arithmetic is WIDTH-bit unsigned. Count never exceeds div, so no overflow wrap occurs. div=all-ones gives a period of 2^WIDTH.
- Channels are fully independent. A cfg_wr to one channel never disturbs another.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- tick is high in the cycle immediately after the terminal edge, coincident with count=0 (free-run) or count=div (one-shot).
- Configuration latency is one clock. The first enabled cycle after a cfg_wr edge increments from 0.
- Reset assertion forces all outputs to their reset values asynchronously, without a clock edge. Deassertion is assumed to be synchronised upstream.
- When cfg_wr, clear and the terminal condition coincide on one channel, cfg_wr wins. No tick is issued and div_clk is not toggled.

## Structure
- Package freq_div_pkg holds:
  - the state enum (FD_RUN, FD_DONE)
  - a width helper function for CH_W
  - a config struct (div, oneshot)
- Sub-module freq_div_chan implements one channel: counter, state, tick, div_clk, done.
- The top level instantiates NUM_CH copies in a generate loop. It decodes cfg_wr/cfg_ch into per-channel write strobes and packs the count outputs.

## Test plan
- Reset, DEFAULT_DIV=1, enable[0]=1 steady -> count[0] sequence 0,1,0,1. tick[0] high every 2nd cycle. div_clk[0] period 4 cycles.
- cfg_wr ch1 div=0 free-run, enable[1]=1 -> tick[1] held high every cycle. div_clk[1] toggles every cycle.
- cfg_wr ch2 div=5 one-shot, enable=1 -> count 0..5. Then tick[2] pulses once and done[2]=1. count holds at 5 while enable stays high. clear[2] -> count=0, done=0.
- ch0 div=7 running, enable[0] low at count=3 for 4 cycles -> count holds at 3 with no tick. On re-enable, count resumes at 4.
- ch3 at count==div with cfg_wr(ch3, div=2) and clear[3] on the same edge -> count=0, tick=0, div_clk=0, new period 3.
- Assert reset mid-count with no clock edge -> all count/tick/div_clk/done read 0 immediately, and div returns to DEFAULT_DIV.
